// File: rtl/nasti_lite_reg_slave.sv
// NASTI-Lite slave register bank: independent AW/W holds commit into NUM_REGS
// registers; reads are served one per cycle from the pre-commit register state.
module nasti_lite_reg_slave #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [ID_WIDTH-1:0]            aw_id,
    input  logic [ADDR_WIDTH-1:0]          aw_addr,
    input  logic [2:0]                     aw_prot,
    input  logic [3:0]                     aw_qos,
    input  logic [3:0]                     aw_region,
    input  logic [USER_WIDTH-1:0]          aw_user,
    input  logic                           aw_valid,
    output logic                           aw_ready,
    input  logic [DATA_WIDTH-1:0]          w_data,
    input  logic [DATA_WIDTH/8-1:0]        w_strb,
    input  logic [USER_WIDTH-1:0]          w_user,
    input  logic                           w_valid,
    output logic                           w_ready,
    output logic [ID_WIDTH-1:0]            b_id,
    output logic [1:0]                     b_resp,
    output logic [USER_WIDTH-1:0]          b_user,
    output logic                           b_valid,
    input  logic                           b_ready,
    input  logic [ID_WIDTH-1:0]            ar_id,
    input  logic [ADDR_WIDTH-1:0]          ar_addr,
    input  logic [2:0]                     ar_prot,
    input  logic [3:0]                     ar_qos,
    input  logic [3:0]                     ar_region,
    input  logic [USER_WIDTH-1:0]          ar_user,
    input  logic                           ar_valid,
    output logic                           ar_ready,
    output logic [ID_WIDTH-1:0]            r_id,
    output logic [DATA_WIDTH-1:0]          r_data,
    output logic [1:0]                     r_resp,
    output logic [USER_WIDTH-1:0]          r_user,
    output logic                           r_valid,
    input  logic                           r_ready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFFS_W = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    logic                  aw_held_q, aw_held_d;
    logic [ID_WIDTH-1:0]   aw_id_q,   aw_id_d;
    logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
    logic                  w_held_q,  w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0]     w_strb_q,  w_strb_d;
    logic                  b_valid_q, b_valid_d;
    logic [ID_WIDTH-1:0]   b_id_q,    b_id_d;
    logic [1:0]            b_resp_q,  b_resp_d;
    logic                  r_valid_q, r_valid_d;
    logic [ID_WIDTH-1:0]   r_id_q,    r_id_d;
    logic [DATA_WIDTH-1:0] r_data_q,  r_data_d;
    logic [1:0]            r_resp_q,  r_resp_d;
    logic [NUM_REGS-1:0]   pulse_q,   pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic             commit;
    logic             ar_hs;
    logic [IDX_W-1:0] ar_idx;

    // Sideband fields and byte-offset address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{aw_prot, aw_qos, aw_region, aw_user, w_user,
                             ar_prot, ar_qos, ar_region, ar_user,
                             aw_addr[OFFS_W-1:0], ar_addr[OFFS_W-1:0]};

    assign aw_ready   = ~aw_held_q;
    assign w_ready    = ~w_held_q;
    assign ar_ready   = ~r_valid_q | r_ready;
    assign commit     = aw_held_q & w_held_q & (~b_valid_q | b_ready);
    assign ar_hs      = ar_valid & ar_ready;
    assign ar_idx     = ar_addr[ADDR_WIDTH-1:OFFS_W];

    assign b_valid    = b_valid_q;
    assign b_id       = b_id_q;
    assign b_resp     = b_resp_q;
    assign b_user     = '0;
    assign r_valid    = r_valid_q;
    assign r_id       = r_id_q;
    assign r_data     = r_data_q;
    assign r_resp     = r_resp_q;
    assign r_user     = '0;
    assign wr_pulse_o = pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    // Write path: independent AW/W holds, commit when both present and B slot free.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_id_d   = aw_id_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_id_d    = b_id_q;
        b_resp_d  = b_resp_q;
        pulse_d   = '0;
        regs_d    = regs_q;

        if (b_valid_q && b_ready) begin
            b_valid_d = 1'b0;
        end
        if (aw_valid && !aw_held_q) begin
            aw_held_d = 1'b1;
            aw_id_d   = aw_id;
            aw_idx_d  = aw_addr[ADDR_WIDTH-1:OFFS_W];
        end
        if (w_valid && !w_held_q) begin
            w_held_d = 1'b1;
            w_data_d = w_data;
            w_strb_d = w_strb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            b_id_d    = aw_id_q;
            b_resp_d  = RESP_DECERR;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (aw_idx_q == IDX_W'(k)) begin
                    b_resp_d   = RESP_OKAY;
                    pulse_d[k] = 1'b1;
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            regs_d[k][b*8 +: 8] = w_data_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read path: sample the registers as they stand before this edge's commit.
    always_comb begin
        r_valid_d = r_valid_q;
        r_id_d    = r_id_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;

        if (r_valid_q && r_ready) begin
            r_valid_d = 1'b0;
        end
        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_id_d    = ar_id;
            r_data_d  = '0;
            r_resp_d  = RESP_DECERR;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (ar_idx == IDX_W'(k)) begin
                    r_data_d = regs_q[k];
                    r_resp_d = RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held_q <= 1'b0;
            aw_id_q   <= '0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
            b_resp_q  <= '0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            pulse_q   <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            aw_id_q   <= aw_id_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_valid_q <= b_valid_d;
            b_id_q    <= b_id_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            pulse_q   <= pulse_d;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

endmodule

// File: tb/tb_nasti_lite_reg_slave.sv
// Directed bench for nasti_lite_reg_slave (default parameters: 16 x 32-bit registers).
module tb_nasti_lite_reg_slave;

    logic         clk = 1'b0;
    logic         rstn;
    logic [0:0]   aw_id;
    logic [7:0]   aw_addr;
    logic [2:0]   aw_prot;
    logic [3:0]   aw_qos;
    logic [3:0]   aw_region;
    logic [0:0]   aw_user;
    logic         aw_valid;
    logic         aw_ready;
    logic [31:0]  w_data;
    logic [3:0]   w_strb;
    logic [0:0]   w_user;
    logic         w_valid;
    logic         w_ready;
    logic [0:0]   b_id;
    logic [1:0]   b_resp;
    logic [0:0]   b_user;
    logic         b_valid;
    logic         b_ready;
    logic [0:0]   ar_id;
    logic [7:0]   ar_addr;
    logic [2:0]   ar_prot;
    logic [3:0]   ar_qos;
    logic [3:0]   ar_region;
    logic [0:0]   ar_user;
    logic         ar_valid;
    logic         ar_ready;
    logic [0:0]   r_id;
    logic [31:0]  r_data;
    logic [1:0]   r_resp;
    logic [0:0]   r_user;
    logic         r_valid;
    logic         r_ready;
    logic [511:0] reg_o;
    logic [15:0]  wr_pulse_o;

    int n_vec     = 0;
    int n_miscmp  = 0;

    always #5 clk = ~clk;

    nasti_lite_reg_slave dut (
        .clk(clk), .rstn(rstn),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_qos(aw_qos),
        .aw_region(aw_region), .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_user(w_user), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_qos(ar_qos),
        .ar_region(ar_region), .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_user(r_user), .r_valid(r_valid),
        .r_ready(r_ready), .reg_o(reg_o), .wr_pulse_o(wr_pulse_o)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] regk(input int k);
        return reg_o[k*32 +: 32];
    endfunction

    // Full write with same-cycle AW+W; B is expected one edge after the handshake edge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic id, input logic [1:0] er, input logic [15:0] ep);
        int n;
        check("wr_aw_ready", aw_ready, 1'b1);
        check("wr_w_ready", w_ready, 1'b1);
        aw_addr = a; aw_id = id; aw_valid = 1'b1;
        w_data = d; w_strb = s; w_valid = 1'b1; b_ready = 1'b1;
        tick;
        aw_valid = 1'b0; w_valid = 1'b0;
        n = 0;
        do begin
            tick;
            n++;
        end while (!b_valid && n < 8);
        check("wr_b_valid", b_valid, 1'b1);
        check("wr_b_latency", n, 1);
        check("wr_b_id", b_id, id);
        check("wr_b_resp", b_resp, er);
        check("wr_pulse", wr_pulse_o, ep);
        tick;
        check("wr_pulse_clear", wr_pulse_o, 16'h0);
        check("wr_b_drain", b_valid, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er,
                      input logic id);
        ar_addr = a; ar_id = id; ar_valid = 1'b1; r_ready = 1'b1;
        tick;
        ar_valid = 1'b0;
        check("rd_r_valid", r_valid, 1'b1);
        check("rd_r_data", r_data, ed);
        check("rd_r_resp", r_resp, er);
        check("rd_r_id", r_id, id);
        tick;
        check("rd_r_drain", r_valid, 1'b0);
    endtask

    initial begin
        logic [511:0] snap;
        logic [7:0]   sa [5];
        logic [31:0]  sd [5];
        logic [1:0]   sr [5];
        logic [31:0]  exp_d [$];
        logic [1:0]   exp_r [$];
        int           issued;
        int           got;
        logic         do_ar;
        logic         do_r;

        rstn = 1'b0;
        aw_id = '0; aw_addr = '0; aw_prot = '0; aw_qos = '0; aw_region = '0; aw_user = '0;
        aw_valid = 1'b0; w_data = '0; w_strb = '0; w_user = '0; w_valid = 1'b0; b_ready = 1'b1;
        ar_id = '0; ar_addr = '0; ar_prot = '0; ar_qos = '0; ar_region = '0; ar_user = '0;
        ar_valid = 1'b0; r_ready = 1'b1;
        repeat (3) tick;
        rstn = 1'b1;
        tick;
        check("rst_aw_ready", aw_ready, 1'b1);
        check("rst_w_ready", w_ready, 1'b1);
        check("rst_ar_ready", ar_ready, 1'b1);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_reg_o", reg_o, 512'h0);
        check("rst_pulse", wr_pulse_o, 16'h0);

        // Reset in the middle of a write drops the pending AW and clears registers.
        wr(8'h04, 32'hCAFEF00D, 4'hF, 1'b0, 2'b00, 16'h0002);
        check("pre_rst_reg1", regk(1), 32'hCAFEF00D);
        aw_addr = 8'h04; aw_id = 1'b1; aw_valid = 1'b1;
        tick;
        aw_valid = 1'b0;
        check("mid_aw_held", aw_ready, 1'b0);
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
        tick;
        check("mid_rst_b_valid", b_valid, 1'b0);
        check("mid_rst_reg_o", reg_o, 512'h0);
        check("mid_rst_aw_ready", aw_ready, 1'b1);
        wr(8'h04, 32'h0BADF00D, 4'hF, 1'b1, 2'b00, 16'h0002);
        check("post_rst_reg1", regk(1), 32'h0BADF00D);

        wr(8'h08, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00, 16'h0004);
        check("reg2_full", regk(2), 32'hDEADBEEF);

        // W arrives three cycles ahead of AW; partial strobe merge.
        w_data = 32'h12345678; w_strb = 4'b0011; w_valid = 1'b1;
        tick;
        w_valid = 1'b0;
        check("wfirst_w_ready", w_ready, 1'b0);
        tick;
        tick;
        check("wfirst_no_b", b_valid, 1'b0);
        check("wfirst_reg2_old", regk(2), 32'hDEADBEEF);
        aw_addr = 8'h08; aw_id = 1'b0; aw_valid = 1'b1;
        tick;
        aw_valid = 1'b0;
        check("wfirst_no_b_yet", b_valid, 1'b0);
        tick;
        check("wfirst_b_valid", b_valid, 1'b1);
        check("wfirst_reg2", regk(2), 32'hDEAD5678);
        check("wfirst_pulse", wr_pulse_o, 16'h0004);
        tick;

        // Out-of-range index.
        rd(8'h40, 32'h0, 2'b11, 1'b0);
        check("r_user_zero", r_user, 1'b0);
        rd(8'h08, 32'hDEAD5678, 2'b00, 1'b1);
        snap = reg_o;
        wr(8'h40, 32'hFFFFFFFF, 4'hF, 1'b0, 2'b11, 16'h0000);
        check("decerr_reg_o", reg_o, snap);
        check("b_user_zero", b_user, 1'b0);

        // B back-pressure: second AW+W captured, its commit waits for the first B.
        b_ready = 1'b0;
        aw_addr = 8'h10; aw_id = 1'b0; aw_valid = 1'b1;
        w_data = 32'h11111111; w_strb = 4'hF; w_valid = 1'b1;
        tick;
        aw_addr = 8'h14; aw_id = 1'b1; w_data = 32'h22222222;
        tick;
        check("bp_b1_valid", b_valid, 1'b1);
        check("bp_reg4", regk(4), 32'h11111111);
        tick;
        aw_valid = 1'b0; w_valid = 1'b0;
        check("bp_aw_ready", aw_ready, 1'b0);
        check("bp_w_ready", w_ready, 1'b0);
        repeat (3) tick;
        check("bp_b_hold", b_valid, 1'b1);
        check("bp_b_id_hold", b_id, 1'b0);
        check("bp_reg5_wait", regk(5), 32'h0);
        b_ready = 1'b1;
        tick;
        check("bp_b2_valid", b_valid, 1'b1);
        check("bp_b2_id", b_id, 1'b1);
        check("bp_b2_resp", b_resp, 2'b00);
        check("bp_reg5", regk(5), 32'h22222222);
        check("bp_pulse", wr_pulse_o, 16'h0020);
        tick;
        check("bp_drain", b_valid, 1'b0);

        // Same-edge read and write of idx3 returns the old value.
        aw_addr = 8'h0C; aw_id = 1'b0; aw_valid = 1'b1;
        w_data = 32'hA5; w_strb = 4'hF; w_valid = 1'b1;
        tick;
        aw_valid = 1'b0; w_valid = 1'b0;
        ar_addr = 8'h0C; ar_id = 1'b1; ar_valid = 1'b1; r_ready = 1'b1;
        tick;
        ar_valid = 1'b0;
        check("rbw_r_valid", r_valid, 1'b1);
        check("rbw_r_data", r_data, 32'h0);
        check("rbw_reg3", regk(3), 32'hA5);
        check("rbw_pulse", wr_pulse_o, 16'h0008);
        tick;
        rd(8'h0C, 32'hA5, 2'b00, 1'b0);

        // Back-to-back reads under random R stalls.
        sa[0] = 8'h08; sd[0] = 32'hDEAD5678; sr[0] = 2'b00;
        sa[1] = 8'h0C; sd[1] = 32'h000000A5; sr[1] = 2'b00;
        sa[2] = 8'h10; sd[2] = 32'h11111111; sr[2] = 2'b00;
        sa[3] = 8'h44; sd[3] = 32'h0;        sr[3] = 2'b11;
        sa[4] = 8'h14; sd[4] = 32'h22222222; sr[4] = 2'b00;
        issued = 0;
        got = 0;
        for (int cyc = 0; cyc < 300 && got < 5; cyc++) begin
            if (!ar_valid && issued < 5) begin
                ar_valid = 1'b1;
                ar_addr = sa[issued];
            end
            r_ready = 1'($urandom_range(0, 1));
            #1;
            do_ar = ar_valid && ar_ready;
            do_r  = r_valid && r_ready;
            if (do_r) begin
                if (exp_d.size() == 0) begin
                    check("stream_extra_beat", got, issued);
                end else begin
                    check("stream_r_data", r_data, exp_d.pop_front());
                    check("stream_r_resp", r_resp, exp_r.pop_front());
                end
                got++;
            end
            tick;
            if (do_ar) begin
                exp_d.push_back(sd[issued]);
                exp_r.push_back(sr[issued]);
                issued++;
                ar_valid = 1'b0;
            end
        end
        ar_valid = 1'b0;
        r_ready = 1'b1;
        check("stream_issued", issued, 5);
        check("stream_got", got, 5);
        tick;
        check("stream_drain", r_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
